// File: rtl/bus_snoop_responder_pkg.sv
// Shared types and the snoop result rule used by the bus snoop responder.
// Defines the bus operation, snoop result and FSM state encodings.
package bus_snoop_responder_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_INVAL = 2'd2,
        OP_RWIM  = 2'd3
    } bus_op_t;

    typedef enum logic [1:0] {
        RES_HIT   = 2'd0,
        RES_HITM  = 2'd1,
        RES_NOHIT = 2'd2
    } snoop_result_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Writebacks are never snooped, so WRITE ignores the address bits.
    function automatic snoop_result_t get_snoop_result(input bus_op_t op, input logic [1:0] addr_lo);
        snoop_result_t res;
        res = RES_NOHIT;
        if (op != OP_WRITE) begin
            if (addr_lo == 2'b00) begin
                res = RES_HIT;
            end else if (addr_lo == 2'b01) begin
                res = RES_HITM;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bus_snoop_responder_sat_counter.sv
// Saturating event counter: increments on inc and sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/bus_snoop_responder.sv
// Models the remote caches on the shared bus: accepts one bus operation at a time,
// optionally replays a dirty-line flush, then returns the snoop result.
module bus_snoop_responder
    import bus_snoop_responder_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int RESP_LATENCY = 2,
    parameter int HITM_BEATS   = 4,
    parameter int CNT_W        = 16,
    localparam int BEAT_W      = (HITM_BEATS > 1) ? $clog2(HITM_BEATS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_result,
    output logic [1:0]        rsp_op,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              flush_valid,
    output logic [BEAT_W-1:0] flush_beat,
    output logic [CNT_W-1:0]  cnt_read,
    output logic [CNT_W-1:0]  cnt_write,
    output logic [CNT_W-1:0]  cnt_inval,
    output logic [CNT_W-1:0]  cnt_rwim,
    output logic [CNT_W-1:0]  cnt_hitm
);

    localparam int WAIT_W = (RESP_LATENCY > 1) ? $clog2(RESP_LATENCY) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(RESP_LATENCY - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(HITM_BEATS - 1);

    state_t              state_q;
    logic [WAIT_W-1:0]   wait_q;
    logic [BEAT_W-1:0]   beat_q;
    bus_op_t             op_q;
    logic [ADDR_W-1:0]   addr_q;
    snoop_result_t       result_q;

    bus_op_t             op_in;
    snoop_result_t       result_d;
    logic                accept;
    logic                take_flush;

    assign op_in      = bus_op_t'(req_op);
    assign result_d   = get_snoop_result(op_in, req_addr[1:0]);
    assign accept     = req_valid && (state_q == ST_IDLE);
    // Only a dirty hit on a read-type op makes the remote owner supply data.
    assign take_flush = (result_q == RES_HITM) && ((op_q == OP_READ) || (op_q == OP_RWIM));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            wait_q   <= '0;
            beat_q   <= '0;
            op_q     <= OP_READ;
            addr_q   <= '0;
            result_q <= RES_NOHIT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q     <= op_in;
                        addr_q   <= req_addr;
                        result_q <= result_d;
                        wait_q   <= WAIT_LOAD;
                        state_q  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_q == '0) begin
                        beat_q  <= '0;
                        state_q <= take_flush ? ST_FLUSH : ST_RESP;
                    end else begin
                        wait_q <= wait_q - WAIT_W'(1);
                    end
                end
                ST_FLUSH: begin
                    if (beat_q == BEAT_LAST) begin
                        state_q <= ST_RESP;
                    end else begin
                        beat_q <= beat_q + BEAT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        beat_q  <= '0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = (state_q == ST_RESP);
    assign flush_valid = (state_q == ST_FLUSH);
    assign flush_beat  = beat_q;
    assign rsp_result  = result_q;
    assign rsp_op      = op_q;
    assign rsp_addr    = addr_q;

    // Statistics are bumped on the acceptance edge, keyed by the incoming op.
    sat_counter #(.CNT_W(CNT_W)) u_cnt_read (
        .clk(clk), .rst(rst), .inc(accept && (op_in == OP_READ)), .count(cnt_read)
    );
    sat_counter #(.CNT_W(CNT_W)) u_cnt_write (
        .clk(clk), .rst(rst), .inc(accept && (op_in == OP_WRITE)), .count(cnt_write)
    );
    sat_counter #(.CNT_W(CNT_W)) u_cnt_inval (
        .clk(clk), .rst(rst), .inc(accept && (op_in == OP_INVAL)), .count(cnt_inval)
    );
    sat_counter #(.CNT_W(CNT_W)) u_cnt_rwim (
        .clk(clk), .rst(rst), .inc(accept && (op_in == OP_RWIM)), .count(cnt_rwim)
    );
    sat_counter #(.CNT_W(CNT_W)) u_cnt_hitm (
        .clk(clk), .rst(rst), .inc(accept && (result_d == RES_HITM)), .count(cnt_hitm)
    );

endmodule

// File: tb/tb_bus_snoop_responder.sv
// Bench for bus_snoop_responder: a default instance plus a CNT_W=2 instance for saturation.
module tb_bus_snoop_responder;

    localparam int LAT   = 2;
    localparam int BEATS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        rsp_ready;
    logic        sel;
    logic [1:0]  req_op;
    logic [31:0] req_addr;

    logic        rdy_a, rv_a, fv_a;
    logic [1:0]  res_a, op_a, fb_a;
    logic [31:0] addr_a;
    logic [15:0] ca_rd, ca_wr, ca_inv, ca_rwim, ca_hitm;

    logic        rdy_b, rv_b, fv_b;
    logic [1:0]  res_b, op_b, fb_b;
    logic [31:0] addr_b;
    logic [1:0]  cb_rd, cb_wr, cb_inv, cb_rwim, cb_hitm;

    logic        o_ready, o_rv, o_fv;
    logic [1:0]  o_res, o_op, o_fb;
    logic [31:0] o_addr;

    int nchk  = 0;
    int nfail = 0;
    int exp_cnt[2][5];
    int cmax[2] = '{65535, 3};

    always #5 clk = ~clk;

    bus_snoop_responder #(.ADDR_W(32), .RESP_LATENCY(LAT), .HITM_BEATS(BEATS), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && !sel), .req_ready(rdy_a), .req_op(req_op), .req_addr(req_addr),
        .rsp_valid(rv_a), .rsp_ready(rsp_ready), .rsp_result(res_a), .rsp_op(op_a), .rsp_addr(addr_a),
        .flush_valid(fv_a), .flush_beat(fb_a),
        .cnt_read(ca_rd), .cnt_write(ca_wr), .cnt_inval(ca_inv), .cnt_rwim(ca_rwim), .cnt_hitm(ca_hitm)
    );

    bus_snoop_responder #(.ADDR_W(32), .RESP_LATENCY(LAT), .HITM_BEATS(BEATS), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && sel), .req_ready(rdy_b), .req_op(req_op), .req_addr(req_addr),
        .rsp_valid(rv_b), .rsp_ready(rsp_ready), .rsp_result(res_b), .rsp_op(op_b), .rsp_addr(addr_b),
        .flush_valid(fv_b), .flush_beat(fb_b),
        .cnt_read(cb_rd), .cnt_write(cb_wr), .cnt_inval(cb_inv), .cnt_rwim(cb_rwim), .cnt_hitm(cb_hitm)
    );

    assign o_ready = sel ? rdy_b  : rdy_a;
    assign o_rv    = sel ? rv_b   : rv_a;
    assign o_fv    = sel ? fv_b   : fv_a;
    assign o_res   = sel ? res_b  : res_a;
    assign o_op    = sel ? op_b   : op_a;
    assign o_fb    = sel ? fb_b   : fb_a;
    assign o_addr  = sel ? addr_b : addr_a;

    function automatic int get_cnt(input int i);
        case (i)
            0:       return sel ? int'(cb_rd)   : int'(ca_rd);
            1:       return sel ? int'(cb_wr)   : int'(ca_wr);
            2:       return sel ? int'(cb_inv)  : int'(ca_inv);
            3:       return sel ? int'(cb_rwim) : int'(ca_rwim);
            default: return sel ? int'(cb_hitm) : int'(ca_hitm);
        endcase
    endfunction

    // Reference result: WRITE or addr[1]=1 gives NOHIT(2); otherwise addr[0] picks HITM(1) / HIT(0).
    function automatic logic [1:0] model_result(input logic [1:0] op, input logic [31:0] a);
        if (op == 2'd1 || a[1]) return 2'd2;
        return a[0] ? 2'd1 : 2'd0;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 5; i++) exp_cnt[d][i] = 0;
    endtask

    task automatic model_accept(input logic [1:0] op, input logic [1:0] res);
        int d;
        d = sel ? 1 : 0;
        if (exp_cnt[d][op] < cmax[d]) exp_cnt[d][op]++;
        if (res == 2'd1 && exp_cnt[d][4] < cmax[d]) exp_cnt[d][4]++;
    endtask

    task automatic check_counters(input string tag);
        for (int i = 0; i < 5; i++) begin
            nchk++;
            if (get_cnt(i) !== exp_cnt[sel ? 1 : 0][i]) begin
                nfail++;
                $display("FAIL %s cnt[%0d]: got %0d expected %0d", tag, i, get_cnt(i), exp_cnt[sel ? 1 : 0][i]);
            end
        end
    endtask

    task automatic wait_rsp(output int k, output int beats, output bit bad_beat);
        k = 0; beats = 0; bad_beat = 0;
        while (!o_rv && k < 60) begin
            if (o_fv) begin
                if (o_fb !== beats[1:0]) bad_beat = 1;
                beats++;
            end
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic run_txn(input logic [1:0] op, input logic [31:0] addr, input string tag);
        int k, beats, exp_lat, w;
        bit bad_beat, flushing;
        logic [1:0] exp_res;
        exp_res  = model_result(op, addr);
        flushing = (exp_res == 2'd1) && (op == 2'd0 || op == 2'd3);
        exp_lat  = LAT + (flushing ? BEATS : 0);
        w = 0;
        while (!o_ready && w < 60) begin @(posedge clk); #1; w++; end
        nchk++;
        if (!o_ready) begin nfail++; $display("FAIL %s ready_timeout: req_ready got 0 expected 1", tag); end
        req_valid = 1'b1; req_op = op; req_addr = addr;
        @(posedge clk); #1;
        req_valid = 1'b0;
        model_accept(op, exp_res);
        wait_rsp(k, beats, bad_beat);
        nchk++;
        if (k != exp_lat || !o_rv) begin
            nfail++; $display("FAIL %s latency: got %0d (rsp_valid=%0b) expected %0d", tag, k, o_rv, exp_lat);
        end
        nchk++;
        if (beats != (flushing ? BEATS : 0) || bad_beat) begin
            nfail++; $display("FAIL %s flush: beats got %0d (bad_index=%0b) expected %0d", tag, beats, bad_beat, flushing ? BEATS : 0);
        end
        nchk++;
        if (o_res !== exp_res || o_op !== op || o_addr !== addr) begin
            nfail++; $display("FAIL %s rsp: res/op/addr got %0d/%0d/%h expected %0d/%0d/%h", tag, o_res, o_op, o_addr, exp_res, op, addr);
        end
        check_counters(tag);
        @(posedge clk); #1;
        nchk++;
        if (o_rv !== 1'b0 || o_ready !== 1'b1 || o_fv !== 1'b0) begin
            nfail++; $display("FAIL %s post_handshake: rv/ready/fv got %0b/%0b/%0b expected 0/1/0", tag, o_rv, o_ready, o_fv);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        int k;
        bit seen;
        sel = 1'b0;
        nchk++;
        if (o_ready !== 1'b1 || o_rv !== 1'b0 || o_res !== 2'd2 || o_op !== 2'd0 ||
            o_addr !== 32'h0 || o_fv !== 1'b0 || o_fb !== 2'd0) begin
            nfail++;
            $display("FAIL reset_values: ready/rv/res/op/addr/fv/fb got %0b/%0b/%0d/%0d/%h/%0b/%0d expected 1/0/2/0/0/0/0",
                     o_ready, o_rv, o_res, o_op, o_addr, o_fv, o_fb);
        end
        check_counters("reset_counters");
        req_valid = 1'b1; req_op = 2'd0; req_addr = 32'h0000_0005;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        nchk++;
        if (o_rv !== 1'b0 || o_fv !== 1'b0 || o_ready !== 1'b1) begin
            nfail++; $display("FAIL reset_in_wait: rv/fv/ready got %0b/%0b/%0b expected 0/0/1", o_rv, o_fv, o_ready);
        end
        model_clear();
        check_counters("reset_in_wait");
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (o_rv || o_fv) seen = 1;
        end
        nchk++;
        if (seen) begin nfail++; $display("FAIL reset_abort: late rsp/flush got 1 expected 0"); end
    endtask

    task automatic test_backpressure();
        int k, beats, w;
        bit bad_beat, unstable;
        sel = 1'b0;
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_op = 2'd0; req_addr = 32'h984D_E130;
        @(posedge clk); #1;
        model_accept(2'd0, 2'd0);
        req_op = 2'd1; req_addr = 32'h0000_0055;
        wait_rsp(k, beats, bad_beat);
        unstable = 0;
        for (w = 0; w < 5; w++) begin
            @(posedge clk); #1;
            if (o_rv !== 1'b1 || o_res !== 2'd0 || o_op !== 2'd0 ||
                o_addr !== 32'h984D_E130 || o_ready !== 1'b0) unstable = 1;
        end
        nchk++;
        if (unstable) begin nfail++; $display("FAIL bp_hold: rsp not stable/ready high got 1 expected 0"); end
        check_counters("bp_hold");
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        nchk++;
        if (o_rv !== 1'b0 || o_ready !== 1'b1) begin
            nfail++; $display("FAIL bp_handshake: rv/ready got %0b/%0b expected 0/1", o_rv, o_ready);
        end
        check_counters("bp_no_early_accept");
        @(posedge clk); #1;
        req_valid = 1'b0;
        model_accept(2'd1, 2'd2);
        nchk++;
        if (o_ready !== 1'b0) begin nfail++; $display("FAIL bp_next_accept: ready got %0b expected 0", o_ready); end
        check_counters("bp_next_accept");
        wait_rsp(k, beats, bad_beat);
        nchk++;
        if (!o_rv || k != LAT || o_res !== 2'd2 || o_op !== 2'd1 || beats != 0) begin
            nfail++; $display("FAIL bp_second_rsp: lat/res/op got %0d/%0d/%0d expected %0d/2/1", k, o_res, o_op, LAT);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_saturate();
        sel = 1'b1;
        for (int i = 0; i < 5; i++) run_txn(2'd0, 32'hABCD_E12E, "sat_read");
        nchk++;
        if (cb_rd !== 2'd3) begin nfail++; $display("FAIL sat_final: cnt_read got %0d expected 3", cb_rd); end
        sel = 1'b0;
    endtask

    task automatic test_random();
        sel = 1'b0;
        for (int i = 0; i < 30; i++) begin
            logic [1:0] op;
            logic [31:0] a;
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            run_txn(op, a, "random");
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1; sel = 1'b0;
        req_op = 2'd0; req_addr = 32'h0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        run_txn(2'd0, 32'h984D_E130, "read_hit");
        run_txn(2'd3, 32'h116D_E12D, "rwim_hitm");
        do_reset();
        run_txn(2'd1, 32'h777D_E131, "write_nohit");
        run_txn(2'd2, 32'h777D_E131, "inval_hitm");
        test_backpressure();
        test_saturate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time got limit expected earlier finish");
        $fatal(1, "timeout");
    end

endmodule
